// File: rtl/ysyx_dispatch_queue.sv
// Multi-lane in-order decoupling queue between decode and RS/ROB dispatch.
// Enqueue is all-or-nothing per cycle; dequeue accepts any lane-0-anchored prefix.
module ysyx_dispatch_queue #(
  parameter int PW    = 160,
  parameter int LANES = 2,
  parameter int DEPTH = 8,
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                flush,
  input  logic [LANES-1:0]    in_valid,
  input  logic [LANES*PW-1:0] in_data,
  output logic                in_ready,
  output logic [LANES-1:0]    out_valid,
  output logic [LANES*PW-1:0] out_data,
  input  logic [LANES-1:0]    out_ready,
  output logic [CW-1:0]       count,
  output logic                proto_err
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]    head_q, head_d;
  logic [AW-1:0]    tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;
  logic             proto_err_q, proto_err_d;
  logic [PW-1:0]    mem_q [DEPTH];
  logic [PW-1:0]    mem_d [DEPTH];
  logic [CW-1:0]    push_n;
  logic [CW-1:0]    pop_n;
  logic [LANES-1:0] pop_mask;

  function automatic logic [CW-1:0] prefix_len(input logic [LANES-1:0] v);
    logic [CW-1:0] n;
    logic          stop;
    n    = '0;
    stop = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      if (!stop && v[i]) n = n + CW'(1);
      else               stop = 1'b1;
    end
    return n;
  endfunction

  // A set bit above a clear bit means the producer/consumer broke the prefix rule.
  function automatic logic has_gap(input logic [LANES-1:0] v);
    logic seen_zero;
    logic gap;
    seen_zero = 1'b0;
    gap       = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      if (!v[i])          seen_zero = 1'b1;
      else if (seen_zero) gap = 1'b1;
    end
    return gap;
  endfunction

  assign in_ready  = count_q <= CW'(DEPTH - LANES);
  assign count     = count_q;
  assign proto_err = proto_err_q;

  always_comb begin
    out_valid = '0;
    out_data  = '0;
    for (int k = 0; k < LANES; k++) begin
      out_valid[k]          = count_q > CW'(k);
      out_data[k*PW +: PW]  = mem_q[head_q + AW'(k)];
    end
  end

  always_comb begin
    pop_mask    = out_valid & out_ready;
    push_n      = in_ready ? prefix_len(in_valid) : '0;
    pop_n       = prefix_len(pop_mask);
    proto_err_d = has_gap(in_valid) | has_gap(pop_mask);
    mem_d       = mem_q;
    for (int i = 0; i < LANES; i++) begin
      if (!flush && (CW'(i) < push_n)) mem_d[tail_q + AW'(i)] = in_data[i*PW +: PW];
    end
    tail_d  = tail_q + AW'(push_n);
    head_d  = head_q + AW'(pop_n);
    count_d = count_q + push_n - pop_n;
    if (flush) begin
      tail_d  = '0;
      head_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      proto_err_q <= 1'b0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      proto_err_q <= proto_err_d;
    end
  end

  // Payload storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_ysyx_dispatch_queue.sv
// Self-checking bench for ysyx_dispatch_queue with LANES=2, DEPTH=8, PW=32.
// A queue-based reference model predicts every registered and combinational output.
module tb_ysyx_dispatch_queue;

  localparam int PW    = 32;
  localparam int LANES = 2;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic                clock;
  logic                reset;
  logic                flush;
  logic [LANES-1:0]    in_valid;
  logic [LANES*PW-1:0] in_data;
  logic                in_ready;
  logic [LANES-1:0]    out_valid;
  logic [LANES*PW-1:0] out_data;
  logic [LANES-1:0]    out_ready;
  logic [CW-1:0]       count;
  logic                proto_err;

  int unsigned  tests_run;
  int unsigned  tests_failed;
  logic [31:0]  model_q[$];
  logic         proto_exp;
  logic [31:0]  seq_in;
  logic [31:0]  seq_out;

  ysyx_dispatch_queue #(.PW(PW), .LANES(LANES), .DEPTH(DEPTH)) dut (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .count     (count),
    .proto_err (proto_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Number of leading ones counted upward from lane 0.
  function automatic int lead_ones(input logic [LANES-1:0] v);
    int n;
    n = 0;
    while (n < LANES && v[n]) n++;
    return n;
  endfunction

  function automatic logic non_contig(input logic [LANES-1:0] v);
    return (lead_ones(v) < LANES) && ((v >> lead_ones(v)) != '0);
  endfunction

  function automatic logic [LANES-1:0] model_valid();
    logic [LANES-1:0] m;
    for (int k = 0; k < LANES; k++) m[k] = (model_q.size() > k);
    return m;
  endfunction

  task automatic check_state(input string phase);
    int sz;
    sz = model_q.size();
    checkOutput({phase, "_count"}, 64'(count), 64'(sz));
    checkOutput({phase, "_in_ready"}, 64'(in_ready), 64'((DEPTH - sz) >= LANES));
    checkOutput({phase, "_out_valid"}, 64'(out_valid), 64'(model_valid()));
    checkOutput({phase, "_proto_err"}, 64'(proto_err), 64'(proto_exp));
    for (int k = 0; k < LANES; k++)
      if (k < sz) checkOutput({phase, "_out_data"}, 64'(out_data[k*PW +: PW]), 64'(model_q[k]));
  endtask

  // One clock cycle: drive, check at negedge, then advance the model at posedge.
  task automatic applyStimulus(input logic [1:0] iv, input logic [1:0] ordy, input logic fl,
                               input logic [31:0] d0, input logic [31:0] d1);
    int p, q;
    logic [LANES-1:0] pm;
    in_valid  = iv;
    out_ready = ordy;
    flush     = fl;
    in_data   = {d1, d0};
    @(negedge clock);
    check_state("cyc");
    p  = ((DEPTH - model_q.size()) >= LANES) ? lead_ones(iv) : 0;
    pm = model_valid() & ordy;
    q  = lead_ones(pm);
    @(posedge clock);
    proto_exp = non_contig(iv) | non_contig(pm);
    if (fl) model_q.delete();
    else begin
      repeat (q) void'(model_q.pop_front());
      if (p > 0) model_q.push_back(d0);
      if (p > 1) model_q.push_back(d1);
    end
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(2'b00, 2'b00, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic drain();
    for (int i = 0; i < 6 && model_q.size() > 0; i++)
      applyStimulus(2'b00, 2'b11, 1'b0, 32'h0, 32'h0);
    checkOutput("drain_empty", 64'(count), 64'd0);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    proto_exp    = 1'b0;
    reset        = 1'b0;
    flush        = 1'b0;
    in_valid     = '0;
    out_ready    = '0;
    in_data      = '0;

    // Reset held for three cycles
    repeat (3) begin
      @(negedge clock);
      check_state("reset");
    end
    @(posedge clock);
    #1 reset = 1'b1;
    idle(1);

    // Basic order
    applyStimulus(2'b11, 2'b00, 1'b0, 32'hA0, 32'hA1);
    applyStimulus(2'b11, 2'b00, 1'b0, 32'hB0, 32'hB1);
    checkOutput("t2_count4", 64'(count), 64'd4);
    checkOutput("t2_lane0_a", 64'(out_data[31:0]), 64'hA0);
    checkOutput("t2_lane1_a", 64'(out_data[63:32]), 64'hA1);
    applyStimulus(2'b00, 2'b11, 1'b0, 32'h0, 32'h0);
    checkOutput("t2_lane0_b", 64'(out_data[31:0]), 64'hB0);
    checkOutput("t2_lane1_b", 64'(out_data[63:32]), 64'hB1);
    applyStimulus(2'b00, 2'b11, 1'b0, 32'h0, 32'h0);
    checkOutput("t2_empty", 64'(count), 64'd0);

    // Full and backpressure
    for (int i = 0; i < 3; i++) applyStimulus(2'b11, 2'b00, 1'b0, 32'h10 + i, 32'h20 + i);
    applyStimulus(2'b01, 2'b00, 1'b0, 32'h30, 32'h31);
    checkOutput("t3_count7", 64'(count), 64'd7);
    checkOutput("t3_not_ready", 64'(in_ready), 64'd0);
    applyStimulus(2'b11, 2'b00, 1'b0, 32'hDEAD, 32'hBEEF);
    checkOutput("t3_hold7", 64'(count), 64'd7);
    applyStimulus(2'b00, 2'b01, 1'b0, 32'h0, 32'h0);
    checkOutput("t3_count6", 64'(count), 64'd6);
    checkOutput("t3_ready", 64'(in_ready), 64'd1);
    drain();

    // Wrap with push 2 / pop 1
    seq_in  = 0;
    seq_out = 0;
    for (int i = 0; i < 12; i++) begin
      if (model_q.size() > 0) begin
        checkOutput("t4_seq", 64'(out_data[31:0]), 64'(seq_out));
        seq_out++;
      end
      applyStimulus(2'b11, 2'b01, 1'b0, seq_in, seq_in + 1);
      if (in_ready === 1'b1 || model_q.size() > 0) begin end
      if (model_q.size() > 0 && model_q[model_q.size()-1] == seq_in + 1) seq_in += 2;
      checkOutput("t4_le8", 64'(count <= CW'(DEPTH)), 64'd1);
    end
    drain();

    // Flush priority
    applyStimulus(2'b11, 2'b00, 1'b0, 32'h1, 32'h2);
    applyStimulus(2'b11, 2'b00, 1'b0, 32'h3, 32'h4);
    applyStimulus(2'b01, 2'b00, 1'b0, 32'h5, 32'h6);
    checkOutput("t5_count5", 64'(count), 64'd5);
    applyStimulus(2'b11, 2'b11, 1'b1, 32'h7, 32'h8);
    checkOutput("t5_flushed", 64'(count), 64'd0);
    checkOutput("t5_no_valid", 64'(out_valid), 64'd0);
    applyStimulus(2'b01, 2'b00, 1'b0, 32'h55, 32'h0);
    checkOutput("t5_first", 64'(out_data[31:0]), 64'h55);
    drain();

    // Protocol error on a gapped valid mask
    applyStimulus(2'b10, 2'b00, 1'b0, 32'h66, 32'h77);
    checkOutput("t6_count0", 64'(count), 64'd0);
    checkOutput("t6_err", 64'(proto_err), 64'd1);
    idle(1);
    checkOutput("t6_err_clear", 64'(proto_err), 64'd0);

    // Randomized traffic with occasional flush and one mid-run reset
    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        reset = 1'b0;
        #1;
        checkOutput("mid_rst_count", 64'(count), 64'd0);
        checkOutput("mid_rst_valid", 64'(out_valid), 64'd0);
        checkOutput("mid_rst_ready", 64'(in_ready), 64'd1);
        model_q.delete();
        proto_exp = 1'b0;
        @(posedge clock);
        #1 reset = 1'b1;
      end
      applyStimulus(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                    ($urandom_range(0, 24) == 0), $urandom, $urandom);
    end
    idle(2);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/ysyx_dispatch_queue.md
Name: ysyx_dispatch_queue

Overview:
- Parametrised multi-lane, in-order decoupling queue between IDU decode output and the RS/ROB dispatch stage.
- Generalises the single-entry IDU→issue pipe payload to LANES-wide enqueue/dequeue with DEPTH-entry buffering.
- Adds valid/ready backpressure, partial dequeue, occupancy reporting, flush, and protocol-error detection.
- Payload is an opaque packed vector of PW bits (alu_op, rd, imm, op1/op2, qj/qk/dest, pnpc, inst, pc, ...).

Parameters:
- PW, 160, payload width per lane in bits.
- LANES, 2, enqueue and dequeue lanes per cycle (1..4).
- DEPTH, 8, entries; power of two, DEPTH >= 2*LANES.
- CW, $clog2(DEPTH)+1, occupancy counter width (derived, not overridden).

Ports:
- clock  in  1  sole clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous flush on branch mispredict or trap redirect.
- in_valid  in  LANES  per-lane enqueue request; lane 0 is oldest.
- in_data  in  LANES*PW  lane i payload at bits [i*PW +: PW].
- in_ready  out  1  all-or-nothing enqueue acceptance for this cycle.
- out_valid  out  LANES  lane k holds entry head+k.
- out_data  out  LANES*PW  lane k payload is entry (head+k) mod DEPTH.
- out_ready  in  LANES  per-lane consumer accept.
- count  out  CW  current occupancy, 0..DEPTH.
- proto_err  out  1  registered pulse on a non-contiguous valid or ready mask.

Behaviour:
- Reset (reset=0, asynchronous) clears head, tail, count and proto_err. Storage is not reset.
- Outputs during and after reset: count=0, out_valid=0, proto_err=0, in_ready=1.
- in_ready is combinational from registered count only: in_ready = (DEPTH - count) >= LANES.
  - In_ready does not look ahead to same-cycle pops.
- Push count P is the length of the contiguous lane-0-anchored prefix of in_valid.
  - P is applied only when in_ready=1; otherwise P=0.
  - Lanes above the first 0 in in_valid are ignored.
- Enqueue writes lane i to storage[(tail+i) mod DEPTH] for i<P, then tail += P (mod DEPTH).
- out_valid[k] = (count > k). This is combinational from the registered count.
- out_data lanes read combinationally from storage.
  - out_data on lanes with out_valid=0 is don't-care; the bench must not check it.
- Pop count Q is the length of the contiguous prefix where out_valid[k] & out_ready[k] holds.
  - head += Q (mod DEPTH).
- Next occupancy: count_next = count + P - Q, computed in CW bits; it never over- or underflows given the rules above.
- Latency: an entry enqueued in cycle t is visible on out_valid from cycle t+1. There is no same-cycle bypass.
- Simultaneous push and pop in one cycle: both apply, and FIFO order is preserved.
- Wrap-around: head and tail are $clog2(DEPTH) bits and wrap naturally.
  - Entries straddling index DEPTH-1→0 dequeue in order.
- Full (count > DEPTH-LANES): in_ready=0, no writes, tail holds.
- Empty (count=0): out_valid=0, Q=0 regardless of out_ready.
- flush=1 takes priority: next cycle head=tail=0, count=0.
  - Same-cycle pushes and pops are discarded.
  - The consumer must treat same-cycle pops as squashed.
- proto_err next cycle = 1 if in_valid or out_ready (masked by out_valid) has a 1 above a 0. Otherwise 0.
  - proto_err is independent of flush.
- Reset asserted mid-operation: all state clears immediately. The first post-reset cycle behaves as empty.

Test Plan (LANES=2, DEPTH=8, PW=32):
1. Reset:
   - Stimulus: hold reset=0 for 3 cycles, then release.
   - Required: count=0, out_valid=2'b00, in_ready=1, proto_err=0 throughout.
2. Basic order:
   - Stimulus: push {0xA1,0xA0}, then {0xB1,0xB0} with out_ready=0.
   - Required: count=4; then out_ready=2'b11 yields out_data lanes 0xA0/0xA1, then 0xB0/0xB1; count reaches 0.
3. Full and backpressure:
   - Stimulus: push pairs until count=7, then present in_valid=2'b11.
   - Required: in_ready=0 at count 7; count stays 7 and tail holds.
   - Then out_ready=2'b01 for one cycle → count 6, in_ready=1.
4. Wrap and partial:
   - Stimulus: run push 2 / pop 1 for 12 cycles with sequential data 0..n.
   - Required: dequeued stream is strictly 0,1,2,... across the index 7→0 wrap; count never exceeds 8.
5. Flush priority:
   - Stimulus: at count=5, assert flush with in_valid=2'b11 and out_ready=2'b11.
   - Required: next cycle count=0, out_valid=0; subsequent push of 0x55 is the first entry out.
6. Protocol error:
   - Stimulus: in_valid=2'b10 at count=0.
   - Required: no entry written (count stays 0); proto_err=1 for exactly one cycle.
